// File: rtl/fe_fetch_pc_unit.sv
// ---------------------------------------------------------------------------
// fe_fetch_pc_unit
//
// Fetch-stage program counter and instruction fetch sequencer.
//
// Holds the architectural PC. Fetches one instruction at a time from
// instruction memory using a request/grant/response handshake. Presents the
// fetched word, its PC and PC + 4 to the rest of the pipeline.
//
// The PC advances only when the held instruction retires. The new PC comes
// from the next-PC mux. If that PC is not word aligned, the unit enters a
// trap state that only reset can leave.
//
// Sequence per instruction:
//   REQ   -> request issued at pc, waits for grant
//   WAIT  -> waits for read data
//   VALID -> instruction held for execution until retire
//   TRAP  -> misaligned PC loaded; unit is dead until reset
//
// Ports
//   clk             in   sole clock, rising edge
//   rst             in   synchronous, active-high reset
//   pc_next_i       in   next PC from the next-PC mux (sampled on retire)
//   retire_i        in   held instruction has completed
//   imem_req_o      out  fetch request
//   imem_addr_o     out  fetch address (always equals pc_o)
//   imem_gnt_i      in   memory accepted the request this cycle
//   imem_rvalid_i   in   read data valid
//   imem_rdata_i    in   instruction word from memory
//   pc_o            out  PC of the held instruction
//   pc_plus_4_o     out  pc_o + 4, wrapping modulo 2^32
//   instr_o         out  held instruction word
//   instr_valid_o   out  instr_o is valid for execution
//   misaligned_o    out  sticky: a misaligned PC was loaded
//
// Parameters
//   RESET_PC        PC loaded on reset; must be 4-byte aligned (not checked)
// ---------------------------------------------------------------------------

module fe_fetch_pc_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,

    // Next-PC selection and retirement
    input  logic [31:0] pc_next_i,
    input  logic        retire_i,

    // Instruction memory port
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,

    // Decode / execute side
    output logic [31:0] pc_o,
    output logic [31:0] pc_plus_4_o,
    output logic [31:0] instr_o,
    output logic        instr_valid_o,
    output logic        misaligned_o
);

    // Canonical RISC-V NOP (addi x0, x0, 0). This is what instr_o holds
    // before the first fetch completes.
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        S_REQ   = 2'd0,
        S_WAIT  = 2'd1,
        S_VALID = 2'd2,
        S_TRAP  = 2'd3
    } state_t;

    state_t      state;
    logic [31:0] pc;
    logic [31:0] instr;
    logic        valid_q;
    logic        trap_q;

    // -----------------------------------------------------------------------
    // Sequencer
    //
    // State, PC, instruction and the status flags all update in one block.
    // Each transition also sets the flag it implies, so instr_valid_o and
    // misaligned_o come straight from flops.
    // -----------------------------------------------------------------------
    // NOTE: every register here is assigned with <=. All of them then sample
    // the pre-edge values, whatever order the statements appear in.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: instr is a datapath register, but it is reset anyway.
            // Decode then sees a defined NOP instead of X before the first fetch.
            state   <= S_REQ;
            pc      <= RESET_PC;
            instr   <= NOP_INSTR;
            valid_q <= 1'b0;
            trap_q  <= 1'b0;
        end else begin
            case (state)
                // Request phase. rvalid is deliberately not looked at here.
                // A response that arrives now belongs to a transaction
                // abandoned by reset, so it is dropped. That also covers
                // gnt and rvalid arriving together.
                S_REQ: begin
                    if (imem_gnt_i) begin
                        state <= S_WAIT;
                    end
                end

                // Response phase. Memory keeps at most one transaction
                // outstanding, so the first rvalid seen here is ours.
                S_WAIT: begin
                    if (imem_rvalid_i) begin
                        instr   <= imem_rdata_i;
                        valid_q <= 1'b1;
                        state   <= S_VALID;
                    end
                end

                // Instruction held for execution. Stall until it retires.
                // pc_next_i is sampled only here.
                S_VALID: begin
                    if (retire_i) begin
                        pc      <= pc_next_i;
                        valid_q <= 1'b0;
                        if (pc_next_i[1:0] != 2'b00) begin
                            trap_q <= 1'b1;
                            state  <= S_TRAP;
                        end else begin
                            state  <= S_REQ;
                        end
                    end
                end

                // Terminal until reset. No requests, no retires, and
                // responses are ignored.
                S_TRAP: begin
                    state <= S_TRAP;
                end

                default: begin
                    state <= S_REQ;
                end
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------

    // The request is a decode of the state register, gated by rst. Reset
    // forces the state back to REQ, so without the gate req would rise while
    // rst is still held high. With the gate it rises in the first cycle that
    // rst is low. No imem_* input reaches any output combinationally.
    assign imem_req_o    = (state == S_REQ) && !rst;
    assign imem_addr_o   = pc;

    assign pc_o          = pc;
    // 32-bit add; the carry out is dropped, so 32'hFFFF_FFFC wraps to 0.
    assign pc_plus_4_o   = pc + 32'd4;
    assign instr_o       = instr;
    assign instr_valid_o = valid_q;
    assign misaligned_o  = trap_q;

endmodule

// File: tb/tb_fe_fetch_pc_unit.sv
// ---------------------------------------------------------------------------
// Testbench for fe_fetch_pc_unit.
//
// The bench acts as the instruction memory, with programmable grant and
// response delays, and as the retire / next-PC source.
//
// Each response it delivers pushes the expected {pc, instr} pair onto a
// scoreboard queue. When instr_valid_o rises, an entry is popped and
// compared against the DUT outputs.
//
// Directed sections cover:
//   - reset values and the first fetch
//   - grant and response stalls
//   - retire stall and redirect
//   - misaligned next PC and the trap
//   - reset in the middle of a transaction
//   - PC wrap-around
// A short random run follows.
// ---------------------------------------------------------------------------

module tb_fe_fetch_pc_unit;

    localparam logic [31:0] RST_PC = 32'h0040_0000;
    localparam logic [31:0] NOP    = 32'h0000_0013;
    localparam logic [31:0] JUNK   = 32'hBAD0_BAD0;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] pc_next_i = '0;
    logic        retire_i = 1'b0;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i = 1'b0;
    logic        imem_rvalid_i = 1'b0;
    logic [31:0] imem_rdata_i = '0;
    logic [31:0] pc_o;
    logic [31:0] pc_plus_4_o;
    logic [31:0] instr_o;
    logic        instr_valid_o;
    logic        misaligned_o;

    exp_t        sb_q[$];
    int          n_vectors = 0;
    int          n_miscompares = 0;
    logic [31:0] exp_pc = RST_PC;
    logic [31:0] last_instr = NOP;

    always #5 clk = ~clk;

    fe_fetch_pc_unit #(.RESET_PC(RST_PC)) dut (
        .clk           (clk),
        .rst           (rst),
        .pc_next_i     (pc_next_i),
        .retire_i      (retire_i),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_gnt_i    (imem_gnt_i),
        .imem_rvalid_i (imem_rvalid_i),
        .imem_rdata_i  (imem_rdata_i),
        .pc_o          (pc_o),
        .pc_plus_4_o   (pc_plus_4_o),
        .instr_o       (instr_o),
        .instr_valid_o (instr_valid_o),
        .misaligned_o  (misaligned_o)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vectors++;
        if (obs !== exp) begin
            n_miscompares++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one clock; sample and drive 1 ns after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst           = 1'b1;
        imem_gnt_i    = 1'b0;
        imem_rvalid_i = 1'b0;
        retire_i      = 1'b0;
        step();
        step();
        check("rst_req",        32'(imem_req_o),    32'd0);
        check("rst_pc",         pc_o,               RST_PC);
        check("rst_pc_plus_4",  pc_plus_4_o,        RST_PC + 32'd4);
        check("rst_instr",      instr_o,            NOP);
        check("rst_valid",      32'(instr_valid_o), 32'd0);
        check("rst_misaligned", 32'(misaligned_o),  32'd0);
        rst        = 1'b0;
        exp_pc     = RST_PC;
        last_instr = NOP;
        sb_q.delete();
        #1;
        check("first_req",  32'(imem_req_o), 32'd1);
        check("first_addr", imem_addr_o,     RST_PC);
    endtask

    // Wait a bounded number of cycles for instr_valid_o, then score it.
    task automatic wait_valid();
        int   k;
        exp_t e;
        k = 0;
        while (!instr_valid_o && k < 8) begin
            step();
            k++;
        end
        check("valid_seen",    32'(instr_valid_o), 32'd1);
        check("fetch_latency", 32'(k),             32'd0);
        if (instr_valid_o) begin
            if (sb_q.size() == 0) begin
                check("sb_nonempty", 32'd0, 32'd1);
            end else begin
                e = sb_q.pop_front();
                check("sb_pc",        pc_o,        e.pc);
                check("sb_instr",     instr_o,     e.instr);
                check("sb_pc_plus_4", pc_plus_4_o, e.pc + 32'd4);
                last_instr = e.instr;
            end
        end
    endtask

    // One fetch starting in REQ. Grant after gnt_dly idle cycles; the
    // response follows rv_dly cycles after the grant (rv_dly >= 1).
    // retire_i is held high with a misaligned pc_next_i throughout: it must
    // be ignored outside VALID. stale also raises rvalid in the grant cycle.
    task automatic fetch(input int gnt_dly, input int rv_dly, input logic [31:0] data, input bit stale);
        retire_i  = 1'b1;
        pc_next_i = 32'hBAD0_0001;
        for (int i = 0; i < gnt_dly; i++) begin
            check("req_held",  32'(imem_req_o), 32'd1);
            check("addr_held", imem_addr_o,     exp_pc);
            step();
        end
        check("req_gnt",  32'(imem_req_o), 32'd1);
        check("addr_gnt", imem_addr_o,     exp_pc);
        imem_gnt_i = 1'b1;
        if (stale) begin
            imem_rvalid_i = 1'b1;
            imem_rdata_i  = JUNK;
        end
        step();
        imem_gnt_i    = 1'b0;
        imem_rvalid_i = 1'b0;
        for (int i = 1; i < rv_dly; i++) begin
            check("wait_no_valid", 32'(instr_valid_o), 32'd0);
            check("wait_no_req",   32'(imem_req_o),    32'd0);
            check("wait_pc",       pc_o,               exp_pc);
            step();
        end
        imem_rvalid_i = 1'b1;
        imem_rdata_i  = data;
        sb_q.push_back('{pc: exp_pc, instr: data});
        step();
        imem_rvalid_i = 1'b0;
        retire_i      = 1'b0;
        wait_valid();
    endtask

    // Stall in VALID for `stall` cycles, then retire to nxt.
    task automatic do_retire(input int stall, input logic [31:0] nxt);
        for (int i = 0; i < stall; i++) begin
            pc_next_i = $urandom;
            check("stall_valid", 32'(instr_valid_o), 32'd1);
            check("stall_pc",    pc_o,               exp_pc);
            check("stall_instr", instr_o,            last_instr);
            check("stall_no_req", 32'(imem_req_o),   32'd0);
            step();
        end
        retire_i  = 1'b1;
        pc_next_i = nxt;
        step();
        retire_i  = 1'b0;
        exp_pc    = nxt;
        check("retire_pc",    pc_o,               nxt);
        check("retire_valid", 32'(instr_valid_o), 32'd0);
        if (nxt[1:0] == 2'b00) begin
            check("redirect_req",  32'(imem_req_o), 32'd1);
            check("redirect_addr", imem_addr_o,     nxt);
        end else begin
            check("trap_misaligned", 32'(misaligned_o), 32'd1);
            check("trap_req",        32'(imem_req_o),   32'd0);
        end
    endtask

    initial begin
        logic [31:0] r;

        // Reset and first fetch
        apply_reset();
        fetch(0, 1, NOP, 1'b0);
        check("first_pc_plus_4", pc_plus_4_o, 32'h0040_0004);

        // Grant and response stalls, with a stale rvalid alongside gnt
        do_retire(0, 32'h0040_0004);
        fetch(3, 4, 32'hDEAD_BEEF, 1'b1);

        // Retire stall and redirect
        do_retire(5, 32'h0040_0100);
        fetch(0, 1, 32'h0000_1234, 1'b0);

        // PC wrap
        do_retire(1, 32'hFFFF_FFFC);
        fetch(1, 2, 32'h0010_0073, 1'b0);
        check("wrap_pc_plus_4", pc_plus_4_o, 32'h0000_0000);

        // Misaligned next PC: trap, then everything is ignored
        do_retire(2, 32'h0040_0102);
        for (int i = 0; i < 4; i++) begin
            retire_i      = 1'b1;
            pc_next_i     = 32'h0040_0200;
            imem_gnt_i    = 1'b1;
            imem_rvalid_i = 1'b1;
            imem_rdata_i  = JUNK;
            step();
            check("trap_sticky",   32'(misaligned_o),  32'd1);
            check("trap_no_req",   32'(imem_req_o),    32'd0);
            check("trap_no_valid", 32'(instr_valid_o), 32'd0);
            check("trap_pc",       pc_o,               32'h0040_0102);
        end
        retire_i      = 1'b0;
        imem_gnt_i    = 1'b0;
        imem_rvalid_i = 1'b0;
        apply_reset();

        // Reset mid-transaction: rvalid one cycle after rst falls is dropped
        imem_gnt_i = 1'b1;
        step();
        imem_gnt_i = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        check("midrst_req",  32'(imem_req_o), 32'd1);
        check("midrst_addr", imem_addr_o,     RST_PC);
        step();
        imem_rvalid_i = 1'b1;
        imem_rdata_i  = JUNK;
        step();
        imem_rvalid_i = 1'b0;
        check("midrst_no_valid", 32'(instr_valid_o), 32'd0);
        check("midrst_instr",    instr_o,            NOP);
        check("midrst_req_again", 32'(imem_req_o),   32'd1);
        check("midrst_addr_again", imem_addr_o,      RST_PC);
        fetch(2, 1, 32'h0050_0093, 1'b0);

        // Short random run with aligned targets
        for (int n = 0; n < 8; n++) begin
            r = $urandom;
            r[1:0] = 2'b00;
            do_retire($urandom_range(0, 3), r);
            fetch($urandom_range(0, 3), $urandom_range(1, 4), $urandom, 1'($urandom_range(0, 1)));
        end

        check("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

endmodule
